// File: rtl/next_pc_unit_pkg.sv
// Shared types and constants for the fetch-stage next-PC generator.
// Imported by next_pc_unit and redirect_arbiter.
package pc_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } pc_state_t;

  typedef enum logic [2:0] {
    SRC_NONE = 3'd0,
    SRC_BR   = 3'd1,
    SRC_JMP  = 3'd2,
    SRC_JR   = 3'd3,
    SRC_EXC  = 3'd4
  } redir_src_t;

  localparam int          PC_STEP          = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8002_0000;
  localparam logic [31:0] DEFAULT_EXC_PC   = 32'h8000_0180;
  localparam logic [31:0] DEFAULT_SEG_MASK = 32'h8000_0000;

endpackage

// File: rtl/next_pc_unit_redirect_arbiter.sv
// Fixed-priority redirect select (exc > jr > jmp > br) with target shaping
// and jump-register misalignment detection. Purely combinational.
module redirect_arbiter
  import pc_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] EXC_PC   = WIDTH'(DEFAULT_EXC_PC),
  parameter logic [WIDTH-1:0] SEG_MASK = WIDTH'(DEFAULT_SEG_MASK)
) (
  input  logic             exc_i,
  input  logic             jr_i,
  input  logic [WIDTH-1:0] jr_target_i,
  input  logic             jmp_i,
  input  logic [WIDTH-1:0] jmp_target_i,
  input  logic             br_taken_i,
  input  logic [WIDTH-1:0] br_target_i,
  output redir_src_t       src_o,
  output logic [WIDTH-1:0] target_o,
  output logic             misalign_o
);

  localparam logic [WIDTH-1:0] WORD_MASK = ~WIDTH'(3);

  always_comb begin
    src_o      = SRC_NONE;
    target_o   = '0;
    misalign_o = 1'b0;
    if (exc_i) begin
      src_o    = SRC_EXC;
      target_o = EXC_PC;
    end else if (jr_i) begin
      // A misaligned JR swallows the whole cycle: no lower-priority source wins.
      if (jr_target_i[1:0] != 2'b00) begin
        misalign_o = 1'b1;
      end else begin
        src_o    = SRC_JR;
        target_o = jr_target_i;
      end
    end else if (jmp_i) begin
      src_o    = SRC_JMP;
      target_o = (jmp_target_i | SEG_MASK) & WORD_MASK;
    end else if (br_taken_i) begin
      src_o    = SRC_BR;
      target_o = br_target_i & WORD_MASK;
    end
  end

endmodule

// File: rtl/next_pc_unit.sv
// Registered fetch PC with prioritised redirects, delay-slot pending state,
// exception vectoring and misaligned-JR reporting.
module next_pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(DEFAULT_RESET_PC),
  parameter logic [WIDTH-1:0] EXC_PC     = WIDTH'(DEFAULT_EXC_PC),
  parameter logic [WIDTH-1:0] SEG_MASK   = WIDTH'(DEFAULT_SEG_MASK),
  parameter bit               DELAY_SLOT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetch_ready,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jmp,
  input  logic [WIDTH-1:0] jmp_target,
  input  logic             jr,
  input  logic [WIDTH-1:0] jr_target,
  input  logic             exc,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             redirect_pending,
  output logic             flush,
  output logic             addr_err
);

  pc_state_t        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
  logic             flush_q, flush_d;
  logic             addr_err_q, addr_err_d;

  redir_src_t       src;
  logic [WIDTH-1:0] target;
  logic             misalign;
  logic [WIDTH-1:0] seq_pc;

  redirect_arbiter #(
    .WIDTH    (WIDTH),
    .EXC_PC   (EXC_PC),
    .SEG_MASK (SEG_MASK)
  ) u_arb (
    .exc_i        (exc),
    .jr_i         (jr),
    .jr_target_i  (jr_target),
    .jmp_i        (jmp),
    .jmp_target_i (jmp_target),
    .br_taken_i   (br_taken),
    .br_target_i  (br_target),
    .src_o        (src),
    .target_o     (target),
    .misalign_o   (misalign)
  );

  // Sequential address wraps naturally modulo 2^WIDTH.
  assign seq_pc = fetch_ready ? pc_q + WIDTH'(PC_STEP) : pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_tgt_d = pend_tgt_q;
    flush_d    = 1'b0;
    addr_err_d = 1'b0;
    if (src == SRC_EXC) begin
      pc_d       = target;
      state_d    = RUN;
      pend_tgt_d = '0;
      flush_d    = 1'b1;
    end else if (state_q == PEND) begin
      // Delay slot not yet fetched; everything except exceptions waits.
      if (fetch_ready) begin
        pc_d    = pend_tgt_q;
        state_d = RUN;
      end
    end else if (misalign) begin
      addr_err_d = 1'b1;
      pc_d       = seq_pc;
    end else if (src != SRC_NONE) begin
      if (!DELAY_SLOT) begin
        pc_d    = target;
        flush_d = 1'b1;
      end else if (fetch_ready) begin
        pc_d = target;
      end else begin
        pend_tgt_d = target;
        state_d    = PEND;
      end
    end else begin
      pc_d = seq_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      flush_q    <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      flush_q    <= flush_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Target storage is only consumed in PEND, which reset leaves; no reset needed.
  always_ff @(posedge clk) begin
    pend_tgt_q <= pend_tgt_d;
  end

  assign pc               = pc_q;
  assign pc_plus4         = pc_q + WIDTH'(PC_STEP);
  assign redirect_pending = (state_q == PEND);
  assign flush            = flush_q;
  assign addr_err         = addr_err_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// Bench for next_pc_unit: delay-slot and immediate-redirect instances driven
// in parallel, table vectors, hand sequences and random traffic vs a model.
module tb_next_pc_unit;

  localparam logic [31:0] R_PC = 32'h8002_0000;
  localparam logic [31:0] E_PC = 32'h8000_0180;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fr, br, jmp, jr, exc;
  logic [31:0] brt, jt, jrt;

  logic [31:0] pc1, pp1, pc0, pp0;
  logic        pend1, flush1, aerr1, pend0, flush0, aerr0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  next_pc_unit #(.DELAY_SLOT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .fetch_ready(fr),
    .br_taken(br), .br_target(brt), .jmp(jmp), .jmp_target(jt),
    .jr(jr), .jr_target(jrt), .exc(exc),
    .pc(pc1), .pc_plus4(pp1), .redirect_pending(pend1),
    .flush(flush1), .addr_err(aerr1)
  );

  next_pc_unit #(.DELAY_SLOT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .fetch_ready(fr),
    .br_taken(br), .br_target(brt), .jmp(jmp), .jmp_target(jt),
    .jr(jr), .jr_target(jrt), .exc(exc),
    .pc(pc0), .pc_plus4(pp0), .redirect_pending(pend0),
    .flush(flush0), .addr_err(aerr0)
  );

  // Reference model: architectural view of one instance.
  typedef struct {
    logic [31:0] pc;
    bit          pend;
    logic [31:0] tgt;
    bit          flush;
    bit          aerr;
  } mstate_t;

  mstate_t m0, m1;

  function automatic mstate_t model_reset();
    mstate_t s;
    s.pc = R_PC; s.pend = 0; s.tgt = 0; s.flush = 0; s.aerr = 0;
    return s;
  endfunction

  function automatic mstate_t model_step(mstate_t s, bit ds);
    logic [31:0] seq, t;
    bit          have;
    seq     = fr ? s.pc + 32'd4 : s.pc;
    s.flush = 0;
    s.aerr  = 0;
    if (exc) begin
      s.pc = E_PC; s.pend = 0; s.tgt = 0; s.flush = 1;
      return s;
    end
    if (s.pend) begin
      if (fr) begin s.pc = s.tgt; s.pend = 0; end
      return s;
    end
    have = 1;
    t    = 0;
    if (jr) begin
      if (jrt % 4 != 0) begin s.aerr = 1; s.pc = seq; return s; end
      t = jrt;
    end else if (jmp) t = ((jt | 32'h8000_0000) / 4) * 4;
    else if (br)      t = (brt / 4) * 4;
    else              have = 0;
    if (!have) s.pc = seq;
    else if (!ds) begin s.pc = t; s.flush = 1; end
    else if (fr) s.pc = t;
    else begin s.pend = 1; s.tgt = t; end
    return s;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic compare_all();
    check("ds1_pc",    pc1, m1.pc);
    check("ds1_pc4",   pp1, m1.pc + 32'd4);
    check("ds1_pend",  {31'd0, pend1},  {31'd0, m1.pend});
    check("ds1_flush", {31'd0, flush1}, {31'd0, m1.flush});
    check("ds1_aerr",  {31'd0, aerr1},  {31'd0, m1.aerr});
    check("ds0_pc",    pc0, m0.pc);
    check("ds0_pc4",   pp0, m0.pc + 32'd4);
    check("ds0_pend",  {31'd0, pend0},  {31'd0, m0.pend});
    check("ds0_flush", {31'd0, flush0}, {31'd0, m0.flush});
    check("ds0_aerr",  {31'd0, aerr0},  {31'd0, m0.aerr});
  endtask

  task automatic tick();
    @(posedge clk);
    m0 = model_step(m0, 1'b0);
    m1 = model_step(m1, 1'b1);
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    fr = 0; br = 0; jmp = 0; jr = 0; exc = 0;
    brt = 0; jt = 0; jrt = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m0 = model_reset();
    m1 = model_reset();
    check("rst_pc1",   pc1, R_PC);
    check("rst_pc0",   pc0, R_PC);
    check("rst_flags", {29'd0, pend1 | pend0, flush1 | flush0, aerr1 | aerr0}, 32'd0);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        fr, br;
    logic [31:0] brt;
    logic        jmp;
    logic [31:0] jt;
    logic        jr;
    logic [31:0] jrt;
    logic        exc;
    logic [31:0] epc;
    logic        epend, eflush, eaerr;
  } vec_t;

  function automatic vec_t mk(logic f, logic b, logic [31:0] bt, logic j, logic [31:0] jtt,
                              logic r, logic [31:0] rt, logic e, logic [31:0] ep,
                              logic epd, logic efl, logic eae);
    vec_t v;
    v.fr = f; v.br = b; v.brt = bt; v.jmp = j; v.jt = jtt; v.jr = r; v.jrt = rt;
    v.exc = e; v.epc = ep; v.epend = epd; v.eflush = efl; v.eaerr = eae;
    return v;
  endfunction

  vec_t tbl[15];

  initial begin
    // Delay-slot instance expectations, applied in order straight out of reset.
    tbl[0]  = mk(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h8002_0004, 1'b0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h8002_0008, 1'b0, 1'b0, 1'b0);
    tbl[2]  = mk(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h8002_000C, 1'b0, 1'b0, 1'b0);
    tbl[3]  = mk(1'b0, 1'b1, 32'h8002_0103, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h8002_000C, 1'b1, 1'b0, 1'b0);
    tbl[4]  = mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h8002_000C, 1'b1, 1'b0, 1'b0);
    tbl[5]  = mk(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h8002_0100, 1'b0, 1'b0, 1'b0);
    tbl[6]  = mk(1'b1, 1'b1, 32'h8002_0200, 1'b1, 32'h0000_4000, 1'b0, 32'h0, 1'b0, 32'h8000_4000, 1'b0, 1'b0, 1'b0);
    tbl[7]  = mk(1'b0, 1'b1, 32'h8002_0300, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h8000_4000, 1'b1, 1'b0, 1'b0);
    tbl[8]  = mk(1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 32'h8002_0400, 1'b1, 32'h8000_0180, 1'b0, 1'b1, 1'b0);
    tbl[9]  = mk(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h8000_0184, 1'b0, 1'b0, 1'b0);
    tbl[10] = mk(1'b1, 1'b1, 32'h8002_0600, 1'b0, 32'h0, 1'b1, 32'h8002_0202, 1'b0, 32'h8000_0188, 1'b0, 1'b0, 1'b1);
    tbl[11] = mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h8002_0202, 1'b0, 32'h8000_0188, 1'b0, 1'b0, 1'b1);
    tbl[12] = mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h8000_0188, 1'b0, 1'b0, 1'b0);
    tbl[13] = mk(1'b1, 1'b1, 32'h8002_0700, 1'b0, 32'h0, 1'b1, 32'h8002_0500, 1'b0, 32'h8002_0500, 1'b0, 1'b0, 1'b0);
    tbl[14] = mk(1'b1, 1'b0, 32'h0, 1'b1, 32'h1234_5677, 1'b0, 32'h0, 1'b0, 32'h9234_5674, 1'b0, 1'b0, 1'b0);

    do_reset();

    for (int i = 0; i < 15; i++) begin
      fr = tbl[i].fr; br = tbl[i].br; brt = tbl[i].brt; jmp = tbl[i].jmp; jt = tbl[i].jt;
      jr = tbl[i].jr; jrt = tbl[i].jrt; exc = tbl[i].exc;
      tick();
      check($sformatf("tbl%0d_pc", i), pc1, tbl[i].epc);
      check($sformatf("tbl%0d_flags", i), {29'd0, pend1, flush1, aerr1},
            {29'd0, tbl[i].epend, tbl[i].eflush, tbl[i].eaerr});
    end

    // Immediate-redirect instance: redirect ignores fetch_ready and flushes.
    idle_inputs();
    br = 1; brt = 32'h8002_0040;
    tick();
    check("ds0_br_pc", pc0, 32'h8002_0040);
    check("ds0_br_flush", {31'd0, flush0}, 32'd1);
    brt = 32'hFFFF_FFFC;
    tick();
    check("ds0_top_pc", pc0, 32'hFFFF_FFFC);
    br = 0; fr = 1;
    tick();
    check("ds0_wrap_pc", pc0, 32'h0000_0000);
    check("ds0_wrap_flush", {31'd0, flush0}, 32'd0);

    // Reset while a delay-slot redirect is pending.
    idle_inputs();
    br = 1; brt = 32'h8002_0700;
    tick();
    check("pend_before_rst", {31'd0, pend1}, 32'd1);
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pc", pc1, R_PC);
    check("async_rst_pend", {31'd0, pend1}, 32'd0);
    @(posedge clk);
    #1;
    m0 = model_reset();
    m1 = model_reset();
    rst_n = 1'b1;
    fr = 1;
    tick();
    check("post_rst_pc", pc1, 32'h8002_0004);

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      fr  = ($urandom_range(0, 9) < 7);
      exc = ($urandom_range(0, 24) == 0);
      jr  = ($urandom_range(0, 9) < 2);
      jmp = ($urandom_range(0, 9) < 2);
      br  = ($urandom_range(0, 9) < 3);
      brt = $urandom;
      jt  = $urandom;
      jrt = $urandom;
      if ($urandom_range(0, 1) == 0) jrt[1:0] = 2'b00;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
